// File: rtl/fmadd_seq_pkg.sv
// Shared encodings for the bfloat16 FMADD sequencer: states, opcodes, stage and flag positions.
package fmadd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GEN  = 3'd1,
    ST_MUL  = 3'd2,
    ST_ADD  = 3'd3,
    ST_NORM = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [1:0] OP_FMADD  = 2'b00;
  localparam logic [1:0] OP_FMSUB  = 2'b01;
  localparam logic [1:0] OP_FNMSUB = 2'b10;
  localparam logic [1:0] OP_FNMADD = 2'b11;

  localparam int NUM_STAGES = 4;
  localparam int STG_GEN    = 0;
  localparam int STG_MUL    = 1;
  localparam int STG_ADD    = 2;
  localparam int STG_NORM   = 3;

  localparam int NUM_FLAGS = 5;
  localparam int FLAG_NV   = 4;
  localparam int FLAG_DZ   = 3;
  localparam int FLAG_OF   = 2;
  localparam int FLAG_UF   = 1;
  localparam int FLAG_NX   = 0;

  // Saturating increment used by the optional performance counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fmadd_seq_sign_cond.sv
// Opcode-driven sign conditioning of the A and C operands; B passes through the sequencer untouched.
module fmadd_seq_sign_cond
  import fmadd_seq_pkg::*;
#(
  parameter int STD  = 15,
  parameter int SIGN = 15
) (
  input  logic [1:0]   op,
  input  logic [STD:0] a,
  input  logic [STD:0] c,
  output logic [STD:0] a_cond,
  output logic [STD:0] c_cond
);

  logic neg_prod;
  logic neg_add;

  // Negating the product is done by flipping A's sign; negating the addend by flipping C's.
  always_comb begin
    neg_prod = 1'b0;
    neg_add  = 1'b0;
    case (op)
      OP_FMSUB:  neg_add = 1'b1;
      OP_FNMSUB: neg_prod = 1'b1;
      OP_FNMADD: begin
        neg_prod = 1'b1;
        neg_add  = 1'b1;
      end
      default: ;
    endcase
    a_cond       = a;
    c_cond       = c;
    a_cond[SIGN] = a[SIGN] ^ neg_prod;
    c_cond[SIGN] = c[SIGN] ^ neg_add;
  end

endmodule

// File: rtl/fmadd_sequencer.sv
// Multi-cycle sequencer for the bfloat16 fused multiply-add datapath.
// Optional counters enabled by defining FMADD_SEQUENCER_PERF_CNT_EN.
module fmadd_sequencer
  import fmadd_seq_pkg::*;
#(
  parameter int STD = 15,
  parameter int MAN = 6,
  parameter int EXP = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [2:0]            in_rm,
  input  logic [STD:0]          in_a,
  input  logic [STD:0]          in_b,
  input  logic [STD:0]          in_c,
  input  logic                  flush,
  output logic                  mg_activation,
  output logic [STD:0]          mg_a,
  output logic [STD:0]          mg_b,
  output logic [STD:0]          mg_c,
  output logic [2:0]            dp_rm,
  output logic [NUM_STAGES-1:0] stg_en,
  input  logic [STD:0]          dp_result,
  input  logic [NUM_FLAGS-1:0]  dp_flags,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [STD:0]          out_result,
  output logic [NUM_FLAGS-1:0]  out_flags,
  output logic                  busy,
  output logic [15:0]           perf_ops,
  output logic [15:0]           perf_stall
);

  // Sign sits just above the exponent and mantissa fields.
  localparam int SIGN = EXP + MAN + 2;

  state_t       state_q, state_d;
  logic         accept;
  logic         capture;
  logic [STD:0] a_cond, c_cond;

  fmadd_seq_sign_cond #(
    .STD  (STD),
    .SIGN (SIGN)
  ) u_sign_cond (
    .op     (in_op),
    .a      (in_a),
    .c      (in_c),
    .a_cond (a_cond),
    .c_cond (c_cond)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Stages advance unconditionally; DONE either retires, chains a new op, or holds.
  always_comb begin
    state_d       = state_q;
    in_ready      = 1'b0;
    stg_en        = '0;
    mg_activation = 1'b0;
    out_valid     = 1'b0;
    busy          = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        in_ready = ~flush;
        if (in_valid) state_d = ST_GEN;
      end
      ST_GEN: begin
        stg_en[STG_GEN] = 1'b1;
        mg_activation   = 1'b1;
        state_d         = ST_MUL;
      end
      ST_MUL: begin
        stg_en[STG_MUL] = 1'b1;
        mg_activation   = 1'b1;
        state_d         = ST_ADD;
      end
      ST_ADD: begin
        stg_en[STG_ADD] = 1'b1;
        mg_activation   = 1'b1;
        state_d         = ST_NORM;
      end
      ST_NORM: begin
        stg_en[STG_NORM] = 1'b1;
        mg_activation    = 1'b1;
        state_d          = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~flush;
        if (out_ready) state_d = in_valid ? ST_GEN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  assign accept  = in_valid & in_ready;
  assign capture = (state_q == ST_NORM) & ~flush;

  // Operands stay frozen from accept to the next accept so the datapath sees stable inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mg_a  <= '0;
      mg_b  <= '0;
      mg_c  <= '0;
      dp_rm <= '0;
    end else if (accept) begin
      mg_a  <= a_cond;
      mg_b  <= in_b;
      mg_c  <= c_cond;
      dp_rm <= in_rm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result <= '0;
      out_flags  <= '0;
    end else if (capture) begin
      out_result <= dp_result;
      out_flags  <= dp_flags;
    end
  end

`ifdef FMADD_SEQUENCER_PERF_CNT_EN
  logic [15:0] ops_q, stall_q;

  // Counters survive flush on purpose; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (out_valid && out_ready && !flush) ops_q <= sat_inc(ops_q);
      if ((state_q == ST_DONE) && !out_ready) stall_q <= sat_inc(stall_q);
    end
  end

  assign perf_ops   = ops_q;
  assign perf_stall = stall_q;
`else
  assign perf_ops   = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_fmadd_sequencer.sv
// Scoreboard bench for fmadd_sequencer: directed cases from the plan plus a randomized run.
module tb_fmadd_sequencer;
  import fmadd_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [2:0]  in_rm = 3'b000;
  logic [15:0] in_a = 16'h0, in_b = 16'h0, in_c = 16'h0;
  logic        flush = 1'b0;
  logic        mg_activation;
  logic [15:0] mg_a, mg_b, mg_c;
  logic [2:0]  dp_rm;
  logic [3:0]  stg_en;
  logic [15:0] dp_result;
  logic [4:0]  dp_flags;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [4:0]  out_flags;
  logic        busy;
  logic [15:0] perf_ops, perf_stall;

  typedef struct {
    logic [15:0] a, b, c;
    logic [2:0]  rm;
    logic [15:0] res;
    logic [4:0]  flags;
    int          acc;
  } txn_t;

  txn_t op_q[$];
  txn_t res_q[$];
  int   pass_cnt = 0, total_cnt = 0;
  int   cycle = 0, last_acc = 0;
  int   tb_ops = 0, tb_stall = 0;
  bit   new_txn = 1'b1;
  int   ready_mode = 0;

  fmadd_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rm(in_rm), .in_a(in_a), .in_b(in_b), .in_c(in_c), .flush(flush),
    .mg_activation(mg_activation), .mg_a(mg_a), .mg_b(mg_b), .mg_c(mg_c), .dp_rm(dp_rm),
    .stg_en(stg_en), .dp_result(dp_result), .dp_flags(dp_flags), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags), .busy(busy),
    .perf_ops(perf_ops), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Consumer readiness: 0 = stall, 1 = always ready, 2 = random.
  always @(negedge clk) out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);

  // Stand-in datapath: one known FMADD answer (2*3+1 = 7), otherwise a scrambled fingerprint.
  function automatic logic [20:0] dp_model(input logic [15:0] a, b, c, input logic [2:0] rm);
    logic [15:0] r;
    logic [4:0]  f;
    if (a == 16'h4000 && b == 16'h4040 && c == 16'h3F80) begin
      r = 16'h40E0;
      f = 5'b0;
    end else begin
      r = a + (b ^ 16'h5A5A) + {c[7:0], c[15:8]} + {13'd0, rm};
      f = r[4:0] ^ a[15:11];
    end
    return {f, r};
  endfunction

  always_comb begin
    if (stg_en[3]) {dp_flags, dp_result} = dp_model(mg_a, mg_b, mg_c, dp_rm);
    else begin
      dp_result = 16'hDEAD;
      dp_flags  = 5'h15;
    end
  end

  // Reference: result = sp*(A*B) + sc*C, expressed by negating the operands that carry each sign.
  function automatic txn_t make_txn(input logic [1:0] op, input logic [15:0] a, b, c,
                                    input logic [2:0] rm);
    txn_t t;
    int   sp, sc;
    case (op)
      OP_FMADD:  begin sp = 1;  sc = 1;  end
      OP_FMSUB:  begin sp = 1;  sc = -1; end
      OP_FNMSUB: begin sp = -1; sc = 1;  end
      default:   begin sp = -1; sc = -1; end
    endcase
    t.a  = (sp < 0) ? {~a[15], a[14:0]} : a;
    t.b  = b;
    t.c  = (sc < 0) ? {~c[15], c[14:0]} : c;
    t.rm = rm;
    {t.flags, t.res} = dp_model(t.a, t.b, t.c, rm);
    t.acc = 0;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    total_cnt++;
    $display("[TB] FAIL %s: got no/unexpected event, expected the handshake to occur", name);
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, b, c,
                               input logic [2:0] rm, input bit keep);
    int   waitc;
    txn_t t;
    in_op = op; in_a = a; in_b = b; in_c = c; in_rm = rm; in_valid = 1'b1;
    #1;
    waitc = 0;
    while (!in_ready && waitc < 60) begin
      @(negedge clk); #1;
      waitc++;
    end
    if (!in_ready) begin
      failNow("accept_timeout");
      in_valid = 1'b0;
    end else begin
      t = make_txn(op, a, b, c, rm);
      t.acc = cycle;
      last_acc = cycle;
      op_q.push_back(t);
      res_q.push_back(t);
      @(posedge clk); #1;
      if (!keep) in_valid = 1'b0;
      in_a = 16'($urandom); in_b = 16'($urandom); in_c = 16'($urandom);
      in_op = 2'($urandom); in_rm = 3'($urandom);
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((res_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk); #3;
      n++;
    end
    if (res_q.size() != 0 || busy) failNow("drain_timeout");
  endtask

  task automatic clearModel();
    op_q.delete();
    res_q.delete();
    new_txn = 1'b1;
  endtask

  // Monitor: operands checked at GEN and NORM, results popped on each output handshake.
  initial forever begin
    @(negedge clk); #2;
    if (!rst) begin
      if (stg_en == 4'b0001 || stg_en == 4'b1000) begin
        if (op_q.size() == 0) failNow("stage_without_op");
        else begin
          checkOutput("mon_mg_a", mg_a, op_q[0].a);
          checkOutput("mon_mg_b", mg_b, op_q[0].b);
          checkOutput("mon_mg_c", mg_c, op_q[0].c);
          checkOutput("mon_dp_rm", dp_rm, op_q[0].rm);
          if (stg_en == 4'b1000) void'(op_q.pop_front());
        end
      end
      if (out_valid) begin
        if (res_q.size() == 0) failNow("unexpected_out_valid");
        else begin
          if (new_txn) begin
            checkOutput("latency", cycle - res_q[0].acc, 5);
            new_txn = 1'b0;
          end
          if (!out_ready) tb_stall++;
          else if (!flush) begin
            checkOutput("out_result", out_result, res_q[0].res);
            checkOutput("out_flags", out_flags, res_q[0].flags);
            void'(res_q.pop_front());
            tb_ops++;
            new_txn = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  d_op[4];
    logic [15:0] d_ma[4];
    logic [15:0] d_mc[4];
    txn_t        bp;
    int          n, first_acc;
    d_op = '{OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD};
    d_ma = '{16'h4000, 16'h4000, 16'hC000, 16'hC000};
    d_mc = '{16'h3F80, 16'hBF80, 16'h3F80, 16'hBF80};

    #12;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_stg_en", stg_en, 0);
    checkOutput("rst_mg_act", mg_activation, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mg_a", mg_a, 0);
    checkOutput("rst_out_result", out_result, 0);
    checkOutput("rst_perf", {perf_ops, perf_stall}, 0);
    ready_mode = 1;
    @(negedge clk); rst = 1'b0;

    $display("[TB] directed opcodes");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(d_op[i], 16'h4000, 16'h4040, 16'h3F80, 3'd0, 1'b0);
      #2;
      checkOutput("dir_mg_a", mg_a, d_ma[i]);
      checkOutput("dir_mg_b", mg_b, 16'h4040);
      checkOutput("dir_mg_c", mg_c, d_mc[i]);
      if (i == 0) begin
        for (int s = 0; s < 4; s++) begin
          checkOutput("stg_seq", stg_en, 32'(1) << s);
          checkOutput("stg_mg_act", mg_activation, 1);
          @(posedge clk); #3;
        end
        checkOutput("done_valid", out_valid, 1);
        checkOutput("done_result", out_result, 16'h40E0);
        checkOutput("done_stg_en", stg_en, 0);
        checkOutput("done_mg_act", mg_activation, 0);
      end
      waitIdle();
    end

    $display("[TB] backpressure");
    @(negedge clk); #3;
    rst = 1'b1; clearModel(); tb_ops = 0; tb_stall = 0;
    #1 rst = 1'b0;
    ready_mode = 0;
    bp = make_txn(OP_FMSUB, 16'h3E12, 16'hC105, 16'h4433, 3'd2);
    @(negedge clk);
    applyStimulus(OP_FMSUB, 16'h3E12, 16'hC105, 16'h4433, 3'd2, 1'b0);
    n = 0;
    do begin @(negedge clk); #3; n++; end while (!out_valid && n < 20);
    if (!out_valid) failNow("bp_wait_valid");
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin @(negedge clk); #3; end
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_result", out_result, bp.res);
      checkOutput("bp_flags", out_flags, bp.flags);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    ready_mode = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("bp_valid_fall", out_valid, 0);
`ifdef FMADD_SEQUENCER_PERF_CNT_EN
    checkOutput("perf_stall_7", perf_stall, 7);
    checkOutput("perf_ops_1", perf_ops, 1);
`else
    checkOutput("perf_stall_off", perf_stall, 0);
    checkOutput("perf_ops_off", perf_ops, 0);
`endif

    $display("[TB] back-to-back");
    @(negedge clk);
    applyStimulus(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'b1);
    first_acc = last_acc;
    applyStimulus(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'b0);
    checkOutput("b2b_spacing", last_acc - first_acc, 5);
    checkOutput("b2b_busy", busy, 1);
    waitIdle();

    $display("[TB] flush in ADD");
    @(negedge clk);
    applyStimulus(OP_FMADD, 16'h1234, 16'h5678, 16'h9ABC, 3'd1, 1'b0);
    n = 0;
    do begin @(negedge clk); #3; n++; end while (stg_en != 4'b0100 && n < 10);
    if (stg_en != 4'b0100) failNow("flush_wait_add");
    flush = 1'b1;
    clearModel();
    #1 checkOutput("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_stg_en", stg_en, 0);
    checkOutput("flush_mg_act", mg_activation, 0);
    checkOutput("flush_busy", busy, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #3;
      checkOutput("flush_no_valid", out_valid, 0);
    end
    flush = 1'b1;
    #1 checkOutput("flush_idle_ready", in_ready, 0);
    flush = 1'b0;
    @(negedge clk);
    applyStimulus(OP_FNMADD, 16'h4000, 16'h4040, 16'h3F80, 3'd4, 1'b0);
    waitIdle();

    $display("[TB] async reset in MUL");
    @(negedge clk);
    applyStimulus(OP_FMSUB, 16'($urandom), 16'($urandom), 16'($urandom), 3'd3, 1'b0);
    n = 0;
    do begin @(negedge clk); #3; n++; end while (stg_en != 4'b0010 && n < 10);
    if (stg_en != 4'b0010) failNow("rst_wait_mul");
    rst = 1'b1;
    clearModel(); tb_ops = 0; tb_stall = 0;
    #1;
    checkOutput("arst_stg_en", stg_en, 0);
    checkOutput("arst_mg_act", mg_activation, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_in_ready", in_ready, 1);
    checkOutput("arst_mg_a", mg_a, 0);
    checkOutput("arst_mg_c", mg_c, 0);
    checkOutput("arst_out_result", out_result, 0);
    checkOutput("arst_perf", {perf_ops, perf_stall}, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] randomized run");
    ready_mode = 2;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 1'b0);
    end
    ready_mode = 1;
    waitIdle();
    @(negedge clk); #3;
`ifdef FMADD_SEQUENCER_PERF_CNT_EN
    checkOutput("final_perf_ops", perf_ops, tb_ops);
    checkOutput("final_perf_stall", perf_stall, tb_stall);
`else
    checkOutput("final_perf_ops_off", perf_ops, 0);
    checkOutput("final_perf_stall_off", perf_stall, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
